// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake and arbiter types for the cache/RAM slice
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, XFER} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search starting one past i_ptr
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    // descending scan: the last hit written is the nearest one after i_ptr
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_valid = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among per-CPU icache/dcache pairs with
// round-robin across CPUs, dcache-first within a CPU, and a hang watchdog.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CPUS-1:0]               iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]               dREN,
  input  logic [CPUS-1:0]               dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]               iwait,
  output logic [CPUS-1:0]               dwait,
  output logic [CPUS-1:0][WORD_W-1:0]   iload,
  output logic [CPUS-1:0][WORD_W-1:0]   dload,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  output logic                          ramREN,
  output logic                          ramWEN,
  input  ramstate_t                     ramstate,
  input  logic [WORD_W-1:0]             ramload,
  output logic                          gnt_valid,
  output logic [2:0]                    gnt_cpu,
  output logic                          gnt_isd,
  output logic                          timeout_err
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  arb_state_t        r_state;
  logic [2:0]        r_ptr, r_cpu, w_idx;
  logic              r_isd, r_wen, r_err;
  logic [WDW-1:0]    r_wd;
  logic [WORD_W-1:0] r_addr, r_store, w_saddr, w_sstore;
  logic [CPUS-1:0]   w_req, w_dreq, w_gsel;
  logic              w_valid, w_xfer, w_ack, w_held, w_drop, w_to, w_sd, w_sw;
  assign w_dreq = dREN | dWEN;
  assign w_req  = w_dreq | iREN;
  rr_picker #(.N(CPUS), .IW(3)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );
  always_comb begin
    w_sd = 1'b0;
    w_sw = 1'b0;
    w_saddr = '0;
    w_sstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (w_idx == 3'(c)) begin
        w_sd = w_dreq[c];
        w_sw = dWEN[c];
        w_saddr = w_dreq[c] ? daddr[c] : iaddr[c];
        w_sstore = dstore[c];
      end
    end
  end
  for (genvar g = 0; g < CPUS; g++) begin : g_sel
    assign w_gsel[g] = r_cpu == 3'(g);
  end
  assign w_xfer = r_state == XFER;
  assign w_ack  = w_xfer && ramstate == ACCESS;
  assign w_held = |((r_isd ? w_dreq : iREN) & w_gsel);
  assign w_drop = w_xfer && !w_ack && !w_held;
  assign w_to   = w_xfer && !w_ack && w_held && r_wd == WDW'(TIMEOUT - 1);
  assign iwait       = ~({CPUS{w_ack & ~r_isd}} & w_gsel);
  assign dwait       = ~({CPUS{w_ack & r_isd}} & w_gsel);
  assign iload       = {CPUS{ramload}};
  assign dload       = {CPUS{ramload}};
  assign ramaddr     = r_addr;
  assign ramstore    = r_store;
  assign ramREN      = w_xfer && !r_wen;
  assign ramWEN      = w_xfer && r_wen;
  assign gnt_valid   = w_xfer;
  assign gnt_cpu     = r_cpu;
  assign gnt_isd     = r_isd;
  assign timeout_err = r_err;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr <= 3'(CPUS - 1);
      r_cpu <= '0;
      r_isd <= 1'b0;
      r_wen <= 1'b0;
      r_addr <= '0;
      r_store <= '0;
      r_wd <= '0;
      r_err <= 1'b0;
    end else if (!w_xfer) begin
      if (w_valid) begin
        r_state <= XFER;
        r_cpu <= w_idx;
        r_isd <= w_sd;
        r_wen <= w_sd && w_sw;
        r_addr <= w_saddr;
        r_store <= w_sstore;
        r_wd <= '0;
      end
    end else if (w_ack || w_drop || w_to) begin
      r_state <= IDLE;
      r_wd <= '0;
      r_ptr <= w_drop ? r_ptr : r_cpu;
      r_err <= r_err || w_to;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, corner sequences and random traffic checked
// against a transaction-level model of the arbiter.
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 2;
  localparam int TO = 255;
  logic CLK = 1'b0, RST = 1'b1;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic [31:0] ramaddr, ramstore, ramload;
  logic ramREN, ramWEN, gnt_valid, gnt_isd, timeout_err;
  logic [2:0] gnt_cpu;
  ramstate_t ramstate;
  int n_tests = 0, n_fail = 0;
  ram_arbiter #(.CPUS(CPUS), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramstate(ramstate), .ramload(ramload), .gnt_valid(gnt_valid),
    .gnt_cpu(gnt_cpu), .gnt_isd(gnt_isd), .timeout_err(timeout_err)
  );
  always #5 CLK = ~CLK;
  // transaction-level model: who owns the RAM, for how long, and who goes next
  bit m_busy, m_isd, m_wen, m_err;
  int m_cpu, m_ptr, m_age;
  logic [31:0] m_addr, m_store;
  typedef struct {
    logic [1:0] i, d, w;
    int cpu;
    bit isd, wen;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_busy = 0; m_isd = 0; m_wen = 0; m_err = 0;
    m_cpu = 0; m_ptr = CPUS - 1; m_age = 0; m_addr = 0; m_store = 0;
  endfunction
  function automatic void model_step();
    bit held;
    if (!m_busy) begin
      for (int k = 1; k <= CPUS; k++) begin
        int c = (m_ptr + k) % CPUS;
        if (iREN[c] | dREN[c] | dWEN[c]) begin
          m_busy = 1; m_cpu = c; m_isd = dREN[c] | dWEN[c];
          m_wen = m_isd && dWEN[c];
          m_addr = m_isd ? daddr[c] : iaddr[c];
          m_store = dstore[c]; m_age = 0;
          break;
        end
      end
    end else begin
      held = m_isd ? (dREN[m_cpu] | dWEN[m_cpu]) : iREN[m_cpu];
      if (ramstate == ACCESS) begin
        m_busy = 0; m_ptr = m_cpu;
      end else if (!held) begin
        m_busy = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_busy = 0; m_err = 1; m_ptr = m_cpu;
        end
      end
    end
  endfunction
  task automatic check_model();
    logic [CPUS-1:0] ei, ed;
    bit ack;
    ei = '1; ed = '1;
    ack = m_busy && ramstate == ACCESS;
    if (ack && m_isd) ed[m_cpu] = 1'b0;
    if (ack && !m_isd) ei[m_cpu] = 1'b0;
    chk("waits", {iwait, dwait}, {ei, ed});
    chk("grant", {gnt_valid, gnt_cpu, gnt_isd, ramREN, ramWEN, timeout_err},
        {m_busy, 3'(m_cpu), m_isd, m_busy && !m_wen, m_busy && m_wen, m_err});
    chk("ramout", {ramaddr, ramstore}, {m_addr, m_store});
    chk("loads", {iload, dload}, {(2 * CPUS){ramload}});
  endtask
  task automatic tick();
    #2 check_model();
    @(posedge CLK);
    model_step();
    #1;
  endtask
  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
  endtask
  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    #1 chk("reset", {gnt_valid, ramREN, ramWEN, iwait, dwait, timeout_err, ramaddr, ramstore, gnt_cpu, gnt_isd},
           {1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0});
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask
  initial begin
    bit saw_ack;
    iaddr[0] = 32'h40; iaddr[1] = 32'h140;
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    dstore[0] = 32'hAAAA0000; dstore[1] = 32'hBBBB0000;
    ramload = 32'h1234_5678;
    tbl[0] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[1] = '{2'b11, 2'b00, 2'b00, 1, 0, 0};
    tbl[2] = '{2'b01, 2'b01, 2'b00, 0, 1, 0};
    tbl[3] = '{2'b01, 2'b00, 2'b01, 0, 1, 1};
    tbl[4] = '{2'b10, 2'b01, 2'b00, 1, 0, 0};
    tbl[5] = '{2'b00, 2'b10, 2'b10, 1, 1, 1};
    tbl[6] = '{2'b10, 2'b00, 2'b01, 0, 1, 1};
    tbl[7] = '{2'b01, 2'b10, 2'b00, 1, 1, 0};
    @(posedge CLK);
    do_reset();
    // reset in the middle of a transfer
    dREN = 2'b10; ramstate = BUSY;
    tick(); tick(); tick();
    do_reset();
    dREN = 2'b11;
    tick();
    chk("rst_ptr", {gnt_valid, gnt_cpu, gnt_isd}, {1'b1, 3'd0, 1'b1});
    ramstate = ACCESS; tick();
    idle_inputs(); tick();
    // dcache beats icache on the same CPU, icache follows after one IDLE
    iREN = 2'b01; dREN = 2'b01; ramstate = BUSY;
    tick();
    chk("d_first", {ramaddr, ramREN, gnt_isd}, {32'h100, 1'b1, 1'b1});
    tick(); tick();
    ramstate = ACCESS;
    #1 chk("d_ack", {dwait, iwait}, {2'b10, 2'b11});
    tick();
    dREN = 2'b00; ramstate = BUSY;
    chk("gap_idle", gnt_valid, 1'b0);
    tick();
    chk("i_next", {ramaddr, gnt_isd, gnt_cpu}, {32'h40, 1'b0, 3'd0});
    ramstate = ACCESS;
    #1 chk("i_ack", {iwait, dwait}, {2'b10, 2'b11});
    tick();
    idle_inputs(); tick();
    // continuous writes from both CPUs alternate
    do_reset();
    dWEN = 2'b11; ramstate = ACCESS;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("alt_wr", {gnt_cpu, ramWEN, ramREN, ramstore},
          {3'(n % 2), 1'b1, 1'b0, (n % 2) ? 32'hBBBB0000 : 32'hAAAA0000});
      tick();
    end
    idle_inputs(); tick();
    // watchdog abort on CPU1, CPU0 served next
    dREN = 2'b10;
    tick();
    dREN = 2'b11;
    saw_ack = 0;
    for (int n = 0; n < TO; n++) begin
      if (n == TO - 1) chk("to_pre", {gnt_valid, timeout_err}, {1'b1, 1'b0});
      #1 if (dwait !== 2'b11) saw_ack = 1;
      tick();
    end
    chk("to_abort", {gnt_valid, timeout_err, saw_ack}, {1'b0, 1'b1, 1'b0});
    tick();
    chk("to_next", {gnt_valid, gnt_cpu, timeout_err}, {1'b1, 3'd0, 1'b1});
    ramstate = ACCESS; tick();
    idle_inputs(); tick();
    // requester drops before ACCESS
    do_reset();
    dREN = 2'b01; ramstate = BUSY;
    tick(); tick();
    dREN = 2'b00;
    tick();
    chk("drop", {gnt_valid, timeout_err, dwait}, {1'b0, 1'b0, 2'b11});
    dREN = 2'b11;
    tick();
    chk("drop_ptr", {gnt_valid, gnt_cpu}, {1'b1, 3'd0});
    ramstate = ACCESS; dREN = 2'b00; dWEN = 2'b00;
    tick();
    // CPU1 read+write: write wins
    dREN = 2'b10; dWEN = 2'b10; ramstate = BUSY;
    tick();
    chk("rw_write", {ramWEN, ramREN, ramaddr, ramstore, gnt_cpu}, {1'b1, 1'b0, 32'h200, 32'hBBBB0000, 3'd1});
    ramstate = ACCESS;
    #1 chk("rw_ack", dwait, 2'b01);
    tick();
    idle_inputs(); tick();
    // arbitration table
    do_reset();
    foreach (tbl[n]) begin
      iREN = tbl[n].i; dREN = tbl[n].d; dWEN = tbl[n].w; ramstate = BUSY;
      tick();
      chk($sformatf("tbl%0d", n), {gnt_valid, gnt_cpu, gnt_isd, ramWEN, ramREN},
          {1'b1, 3'(tbl[n].cpu), tbl[n].isd, tbl[n].wen, !tbl[n].wen});
      ramstate = ACCESS; tick();
      idle_inputs(); tick();
    end
    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 9) < 2) iREN[c] = ~iREN[c];
        if ($urandom_range(0, 9) < 2) dREN[c] = ~dREN[c];
        if ($urandom_range(0, 9) < 1) dWEN[c] = ~dWEN[c];
        if ($urandom_range(0, 31) == 0) iaddr[c] = $urandom;
        if ($urandom_range(0, 31) == 0) daddr[c] = $urandom;
        if ($urandom_range(0, 31) == 0) dstore[c] = $urandom;
      end
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Multicore RAM arbiter and sequencer.
- Shares the single RAM port between CPUS cache pairs (one icache and one dcache per CPU), using round-robin across CPUs and dcache-over-icache priority within a CPU.
- Locks a grant for the whole RAM transaction and releases it on ramstate ACCESS.
- A watchdog aborts hung transactions. Sits between per-CPU caches and the RAM model, in place of single-CPU pass-through arbitration.

Parameters:
- CPUS, 2, number of CPUs (each one icache and one dcache requester); must be 1..8
- TIMEOUT, 255, max cycles a granted transaction may wait for ACCESS before forced abort

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- iREN  in  CPUS  icache read request per CPU
- iaddr  in  CPUS x 32  icache word address
- dREN  in  CPUS  dcache read request
- dWEN  in  CPUS  dcache write request
- daddr  in  CPUS x 32  dcache address
- dstore  in  CPUS x 32  dcache write data
- iwait  out  CPUS  icache stall; 0 only in the ack cycle
- dwait  out  CPUS  dcache stall; 0 only in the ack cycle
- iload  out  CPUS x 32  ramload broadcast to every CPU
- dload  out  CPUS x 32  ramload broadcast to every CPU
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM
- ramload  in  32  RAM read data
- gnt_valid  out  1  a transaction is in flight
- gnt_cpu  out  3  CPU index of the in-flight grant
- gnt_isd  out  1  in-flight grant is dcache (1) or icache (0)
- timeout_err  out  1  sticky; set on any watchdog abort

Behaviour:
- Reset (async, RST=1):
  - FSM=IDLE; rr_ptr=CPUS-1, so CPU0 is searched first; watchdog=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - All iwait/dwait=1; gnt_valid=0; gnt_cpu=0; gnt_isd=0; timeout_err=0.
- FSM IDLE:
  - Search CPUs starting at rr_ptr+1 mod CPUS.
  - First CPU with any request wins. Within that CPU, dcache (dREN|dWEN) beats iREN.
  - On a win: register cpu index, isd, address, store data and op; go to XFER next cycle.
  - No request: stay IDLE; ram enables 0.
- FSM XFER:
  - Ram outputs come from registered grant fields only. The first ram request is one cycle after the request was seen in IDLE.
  - dWEN and dREN both high: write wins; ramWEN=1, ramREN=0.
  - ramstate==ACCESS: deassert the granted requester's wait combinationally for that cycle. rr_ptr<=gnt_cpu; watchdog<=0; next state IDLE.
  - FREE/BUSY/ERROR: all waits stay 1; watchdog increments.
  - watchdog reaches TIMEOUT with no ACCESS: abort with no ack, set timeout_err, rr_ptr<=gnt_cpu, go to IDLE.
  - Granted requester drops its request before ACCESS: abort with no ack, no error, rr_ptr unchanged, go to IDLE.
  - Requests from other requesters during XFER are ignored until IDLE.
- Waits:
  - Every non-granted requester sees wait=1 every cycle.
  - Minimum transaction is 2 cycles (IDLE arbitrate, XFER ack). Back-to-back grants are separated by exactly one IDLE cycle.
- Data paths:
  - iload/dload = ramload unconditionally; consumers sample only on wait=0.
  - ramaddr = granted address, zero-extended; ramstore = granted dstore.
- gnt_valid=1 exactly in XFER. gnt_cpu/gnt_isd hold the last grant while IDLE.
- timeout_err clears only on RST.

Decomposition:
- cpu_types_pkg holds ramstate_t; it is reused, not redefined.
- arb_state_t (IDLE, XFER) and the word width go in cpu_types_pkg alongside it.
- One sub-module, rr_picker: combinational round-robin search returning valid/index given a request vector and pointer. It is reusable by a future coherence bus arbiter.

Test Plan:
- Reset mid-XFER (CPU1 dREN, ramstate BUSY) -> next edge after RST: ramREN=0, all waits 1, gnt_valid=0, rr_ptr picks CPU0 first.
- CPU0 iREN=1 (iaddr=0x40) and CPU0 dREN=1 (daddr=0x100) together, ramstate ACCESS after 2 BUSY cycles -> ramaddr=0x100, dwait[0]=0 for one cycle. Icache served next, with ramaddr=0x40 after one IDLE cycle.
- CPU0 and CPU1 both dWEN continuously, ramstate always ACCESS -> grants alternate 0,1,0,1. Each write asserts ramWEN with the correct ramstore (0xAAAA0000 / 0xBBBB0000).
- CPU1 dREN, ramstate held FREE for 255 cycles -> abort at cycle 255, timeout_err=1, dwait[1] never 0. CPU0 request is granted next.
- CPU0 dREN granted, dREN dropped before ACCESS -> return to IDLE, no ack, timeout_err stays 0, CPU0 remains eligible first.
- CPU1 dREN=dWEN=1 (addr 0x200) -> ramWEN=1, ramREN=0; ack on ACCESS.
